holy_line_transfer_fsm: RTL

- Parametrised cache-line transfer engine: optionally writes back a dirty line, then refills a line, over one AXI master port.
- Burst mode uses AXI4 INCR bursts; lite mode uses one AXI-lite-style single-beat transaction per word. Mode is selected per request.
- Sits between the holy core data/instruction cache array and the SoC interconnect, replacing per-cache hand-coded FSMs.

---
 rtl/holy_line_transfer_fsm.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/holy_line_transfer_fsm.sv
// Cache-line transfer engine: optional dirty-line write-back, then refill, over one AXI4 master port.
// Optional perf counters (perf_xfers, perf_stall) are built only when HOLY_LINE_XFER_PERF_EN is defined.
package holy_core_pkg;
   typedef enum logic [3:0] {
      IDLE,
      SENDING_WRITE_REQ,
      SENDING_WRITE_DATA,
      WAITING_WRITE_RES,
      SENDING_READ_REQ,
      RECEIVING_READ_DATA,
      LITE_SENDING_WRITE_REQ,
      LITE_SENDING_WRITE_DATA,
      LITE_WAITING_WRITE_RES,
      LITE_SENDING_READ_REQ,
      LITE_RECEIVING_READ_DATA
   } cache_state_t;
endpackage

module holy_line_transfer_fsm
   import holy_core_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int LINE_WORDS = 128
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_writeback,
   input  logic                          req_lite,
   input  logic [ADDR_WIDTH-1:0]         req_wb_addr,
   input  logic [ADDR_WIDTH-1:0]         req_fill_addr,
   output logic [$clog2(LINE_WORDS)-1:0] line_rd_idx,
   input  logic [DATA_WIDTH-1:0]         line_rd_data,
   output logic                          line_wr_en,
   output logic [$clog2(LINE_WORDS)-1:0] line_wr_idx,
   output logic [DATA_WIDTH-1:0]         line_wr_data,
   output logic                          done,
   output logic                          error,
   output logic                          awvalid,
   input  logic                          awready,
   output logic [ADDR_WIDTH-1:0]         awaddr,
   output logic [7:0]                    awlen,
   output logic [2:0]                    awsize,
   output logic [1:0]                    awburst,
   output logic                          wvalid,
   input  logic                          wready,
   output logic [DATA_WIDTH-1:0]         wdata,
   output logic [DATA_WIDTH/8-1:0]       wstrb,
   output logic                          wlast,
   input  logic                          bvalid,
   output logic                          bready,
   input  logic [1:0]                    bresp,
   output logic                          arvalid,
   input  logic                          arready,
   output logic [ADDR_WIDTH-1:0]         araddr,
   output logic [7:0]                    arlen,
   output logic [2:0]                    arsize,
   output logic [1:0]                    arburst,
   input  logic                          rvalid,
   output logic                          rready,
   input  logic [DATA_WIDTH-1:0]         rdata,
   input  logic [1:0]                    rresp,
   input  logic                          rlast
`ifdef HOLY_LINE_XFER_PERF_EN
   ,
   output logic [31:0]                   perf_xfers,
   output logic [31:0]                   perf_stall
`endif
);

   localparam int IDX_W                 = $clog2(LINE_WORDS);
   localparam int BYTE_SHIFT            = $clog2(DATA_WIDTH / 8);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);
   localparam logic [7:0] BURST_LEN     = 8'(LINE_WORDS - 1);
   localparam logic [2:0] BEAT_SIZE     = 3'(BYTE_SHIFT);
   localparam logic [1:0] BURST_INCR    = 2'b01;

   cache_state_t          r_state;
   cache_state_t          w_nextState;
   logic [IDX_W-1:0]      r_count;
   logic [IDX_W-1:0]      w_nextCount;
   logic                  r_errAcc;
   logic                  w_nextErr;
   logic                  r_done;
   logic                  r_lite;
   logic [ADDR_WIDTH-1:0] r_wbAddr;
   logic [ADDR_WIDTH-1:0] r_fillAddr;
   logic                  w_accept;
   logic                  w_complete;
   logic                  w_lastWord;
   logic [ADDR_WIDTH-1:0] w_wordOffset;

   assign w_lastWord   = (r_count == LAST_IDX);
   assign w_wordOffset = ADDR_WIDTH'(r_count) << BYTE_SHIFT;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // The word counter is cleared on every phase change, so each phase starts at word 0.
   always_comb begin
      w_nextState = r_state;
      w_nextCount = r_count;
      w_nextErr   = r_errAcc;
      w_accept    = 1'b0;
      w_complete  = 1'b0;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               w_accept    = 1'b1;
               w_nextCount = '0;
               w_nextErr   = 1'b0;
               if (req_writeback) begin
                  w_nextState = req_lite ? LITE_SENDING_WRITE_REQ : SENDING_WRITE_REQ;
               end else begin
                  w_nextState = req_lite ? LITE_SENDING_READ_REQ : SENDING_READ_REQ;
               end
            end
         end
         SENDING_WRITE_REQ: begin
            if (awready) begin
               w_nextState = SENDING_WRITE_DATA;
               w_nextCount = '0;
            end
         end
         SENDING_WRITE_DATA: begin
            if (wready) begin
               if (w_lastWord) begin
                  w_nextState = WAITING_WRITE_RES;
                  w_nextCount = '0;
               end else begin
                  w_nextCount = r_count + IDX_W'(1);
               end
            end
         end
         WAITING_WRITE_RES: begin
            if (bvalid) begin
               if (bresp != 2'b00) w_nextErr = 1'b1;
               w_nextState = SENDING_READ_REQ;
               w_nextCount = '0;
            end
         end
         SENDING_READ_REQ: begin
            if (arready) begin
               w_nextState = RECEIVING_READ_DATA;
               w_nextCount = '0;
            end
         end
         RECEIVING_READ_DATA: begin
            if (rvalid) begin
               if (rresp != 2'b00 || rlast != w_lastWord) w_nextErr = 1'b1;
               if (w_lastWord) begin
                  w_nextState = IDLE;
                  w_nextCount = '0;
                  w_complete  = 1'b1;
               end else begin
                  w_nextCount = r_count + IDX_W'(1);
               end
            end
         end
         LITE_SENDING_WRITE_REQ: begin
            if (awready) w_nextState = LITE_SENDING_WRITE_DATA;
         end
         LITE_SENDING_WRITE_DATA: begin
            if (wready) w_nextState = LITE_WAITING_WRITE_RES;
         end
         LITE_WAITING_WRITE_RES: begin
            if (bvalid) begin
               if (bresp != 2'b00) w_nextErr = 1'b1;
               if (w_lastWord) begin
                  w_nextState = LITE_SENDING_READ_REQ;
                  w_nextCount = '0;
               end else begin
                  w_nextState = LITE_SENDING_WRITE_REQ;
                  w_nextCount = r_count + IDX_W'(1);
               end
            end
         end
         LITE_SENDING_READ_REQ: begin
            if (arready) w_nextState = LITE_RECEIVING_READ_DATA;
         end
         LITE_RECEIVING_READ_DATA: begin
            if (rvalid) begin
               if (rresp != 2'b00) w_nextErr = 1'b1;
               if (w_lastWord) begin
                  w_nextState = IDLE;
                  w_nextCount = '0;
                  w_complete  = 1'b1;
               end else begin
                  w_nextState = LITE_SENDING_READ_REQ;
                  w_nextCount = r_count + IDX_W'(1);
               end
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count    <= '0;
         r_errAcc   <= 1'b0;
         r_done     <= 1'b0;
         r_lite     <= 1'b0;
         r_wbAddr   <= '0;
         r_fillAddr <= '0;
      end else begin
         r_count  <= w_nextCount;
         r_errAcc <= w_nextErr;
         r_done   <= w_complete;
         if (w_accept) begin
            r_lite     <= req_lite;
            r_wbAddr   <= req_wb_addr;
            r_fillAddr <= req_fill_addr;
         end
      end
   end

   // Handshake signals decode from state only, so reset drops every valid immediately.
   assign req_ready = (r_state == IDLE);
   assign awvalid   = (r_state == SENDING_WRITE_REQ) || (r_state == LITE_SENDING_WRITE_REQ);
   assign wvalid    = (r_state == SENDING_WRITE_DATA) || (r_state == LITE_SENDING_WRITE_DATA);
   assign bready    = (r_state == WAITING_WRITE_RES) || (r_state == LITE_WAITING_WRITE_RES);
   assign arvalid   = (r_state == SENDING_READ_REQ) || (r_state == LITE_SENDING_READ_REQ);
   assign rready    = (r_state == RECEIVING_READ_DATA) || (r_state == LITE_RECEIVING_READ_DATA);

   assign awaddr  = r_wbAddr + (r_lite ? w_wordOffset : '0);
   assign awlen   = r_lite ? 8'd0 : BURST_LEN;
   assign awsize  = BEAT_SIZE;
   assign awburst = BURST_INCR;
   assign araddr  = r_fillAddr + (r_lite ? w_wordOffset : '0);
   assign arlen   = r_lite ? 8'd0 : BURST_LEN;
   assign arsize  = BEAT_SIZE;
   assign arburst = BURST_INCR;

   assign wdata = line_rd_data;
   assign wstrb = '1;
   assign wlast = ((r_state == SENDING_WRITE_DATA) && w_lastWord) ||
                  (r_state == LITE_SENDING_WRITE_DATA);

   assign line_rd_idx  = r_count;
   assign line_wr_idx  = r_count;
   assign line_wr_data = rdata;
   assign line_wr_en   = rready & rvalid;

   assign done  = r_done;
   assign error = r_done & r_errAcc;

`ifdef HOLY_LINE_XFER_PERF_EN
   logic [31:0] r_perfXfers;
   logic [31:0] r_perfStall;
   logic        w_stall;

   assign w_stall = (awvalid & ~awready) | (wvalid & ~wready) | (bvalid & ~bready) |
                    (arvalid & ~arready) | (rvalid & ~rready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perfXfers <= '0;
         r_perfStall <= '0;
      end else begin
         if (w_complete) r_perfXfers <= r_perfXfers + 32'd1;
         if (w_stall)    r_perfStall <= r_perfStall + 32'd1;
      end
   end

   assign perf_xfers = r_perfXfers;
   assign perf_stall = r_perfStall;
`endif

endmodule
